// File: rtl/debouncer_bank_pkg.sv
// Shared helpers for the push-button conditioner bank.
// clog2 never returns less than 1 so degenerate counters still get a real bit.
package debouncer_bank_pkg;

  function automatic int clog2(input int value);
    int width;
    width = 1;
    for (int b = 1; b < 31; b++) begin
      if ((1 << b) < value) width = b + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/debouncer_ch.sv
// One button channel: synchroniser, debounce filter, edge pulses, long-press
// detection and optional auto-repeat, all advanced by the shared hold tick.
module debouncer_ch
  import debouncer_bank_pkg::*;
#(
  parameter int CN       = 240000,
  parameter int LONG     = 1000,
  parameter int RPT      = 100,
  parameter bit POL_I    = 1'b1,
  parameter bit RPT_EN_I = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  input  logic i_tick,
  output logic o_d,
  output logic o_p,
  output logic o_r,
  output logic o_l,
  output logic o_a
);

  localparam int CW = clog2(CN);
  localparam int HW = clog2(LONG + 1);
  localparam int RW = clog2(RPT);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CN - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG);
  localparam logic [RW-1:0] RPT_LAST  = RW'(RPT - 1);

  logic          r_sync;
  logic          r_s;
  logic          r_d;
  logic          r_p;
  logic          r_r;
  logic          r_l;
  logic          r_a;
  logic [CW-1:0] r_cnt;
  logic [HW-1:0] r_hold;
  logic [RW-1:0] r_rpt;

  logic w_diff;
  logic w_done;
  logic w_rise;
  logic w_fall;
  logic w_hold_en;
  logic w_l_set;
  logic w_rpt_wrap;

  assign w_diff     = r_s ^ r_d;
  assign w_done     = w_diff && (r_cnt == CNT_LAST);
  assign w_rise     = w_done && r_s;
  assign w_fall     = w_done && !r_s;
  // The press cycle itself never counts a tick, so hold starts from a clean zero.
  assign w_hold_en  = r_d && !r_p;
  assign w_l_set    = w_hold_en && i_tick && (r_hold == HOLD_LAST);
  assign w_rpt_wrap = r_l && i_tick && (r_rpt == RPT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= 1'b0;
      r_s    <= 1'b0;
      r_d    <= 1'b0;
      r_p    <= 1'b0;
      r_r    <= 1'b0;
      r_l    <= 1'b0;
      r_a    <= 1'b0;
      r_cnt  <= '0;
      r_hold <= '0;
      r_rpt  <= '0;
    end else begin
      r_sync <= i_d ^ POL_I;
      r_s    <= r_sync;
      r_cnt  <= (w_diff && !w_done) ? r_cnt + 1'b1 : '0;
      if (w_done) r_d <= r_s;
      r_p <= w_rise;
      r_r <= w_fall;

      if (!w_hold_en) r_hold <= '0;
      else if (i_tick && (r_hold != HOLD_MAX)) r_hold <= r_hold + 1'b1;

      // A release landing on the same edge as the long-press threshold wins.
      if (w_fall) r_l <= 1'b0;
      else if (w_l_set) r_l <= 1'b1;

      if (!r_l) r_rpt <= '0;
      else if (i_tick) r_rpt <= (r_rpt == RPT_LAST) ? '0 : r_rpt + 1'b1;

      r_a <= !w_fall && (w_l_set || w_rpt_wrap);
    end
  end

  assign o_d = r_d;
  assign o_p = r_p;
  assign o_r = r_r;
  assign o_l = r_l;
  assign o_a = RPT_EN_I ? r_a : 1'b0;

endmodule

// File: rtl/debouncer_bank.sv
// N-channel push-button conditioner: one shared hold-tick prescaler feeding
// an array of independent debouncer channels.
module debouncer_bank
  import debouncer_bank_pkg::*;
#(
  parameter int             N      = 4,
  parameter int             CN     = 240000,
  parameter logic [N-1:0]   POL    = 4'hF,
  parameter int             TICK   = 24000,
  parameter int             LONG   = 1000,
  parameter int             RPT    = 100,
  parameter logic [N-1:0]   RPT_EN = 4'h0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] d_o,
  output logic [N-1:0] p_o,
  output logic [N-1:0] r_o,
  output logic [N-1:0] l_o,
  output logic [N-1:0] a_o
);

  localparam int TW = clog2(TICK);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK - 1);

  logic [TW-1:0] r_pre;
  logic          w_tick;

  assign w_tick = (r_pre == TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst) r_pre <= '0;
    else if (w_tick) r_pre <= '0;
    else r_pre <= r_pre + 1'b1;
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_ch
      debouncer_ch #(
        .CN       (CN),
        .LONG     (LONG),
        .RPT      (RPT),
        .POL_I    (POL[gi]),
        .RPT_EN_I (RPT_EN[gi])
      ) u_ch (
        .clk    (clk),
        .rst    (rst),
        .i_d    (d_i[gi]),
        .i_tick (w_tick),
        .o_d    (d_o[gi]),
        .o_p    (p_o[gi]),
        .o_r    (r_o[gi]),
        .o_l    (l_o[gi]),
        .o_a    (a_o[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_debouncer_bank.sv
// Bench for debouncer_bank: vector table, directed corner sequences and random
// stimulus, all compared every cycle against a behavioural model of the bank.
module tb_debouncer_bank;

  localparam int N    = 2;
  localparam int CN   = 4;
  localparam int TICK = 2;
  localparam int LONG = 5;
  localparam int RPT  = 3;
  localparam logic [N-1:0] POL    = 2'b01;
  localparam logic [N-1:0] RPT_EN = 2'b01;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] d_i = 2'b01;
  logic [N-1:0] d_o, p_o, r_o, l_o, a_o;

  always #5 clk = ~clk;

  debouncer_bank #(
    .N(N), .CN(CN), .POL(POL), .TICK(TICK), .LONG(LONG), .RPT(RPT), .RPT_EN(RPT_EN)
  ) dut (
    .clk(clk), .rst(rst), .d_i(d_i),
    .d_o(d_o), .p_o(p_o), .r_o(r_o), .l_o(l_o), .a_o(a_o)
  );

  int checks = 0;
  int errors = 0;
  int t = 0;

  // Behavioural model: s is x delayed two samples; d flips once s has disagreed
  // for CN consecutive samples; held counts ticks since the press cycle.
  int m_s1[N], m_s2[N], m_d[N], m_run[N], m_held[N];
  int m_p[N], m_r[N], m_l[N], m_a[N];
  int m_cyc = 0;

  // Event bookkeeping from observed outputs.
  int n_p[N], n_r[N], n_a[N], n_l[N];
  int t_p[N], t_r[N], t_a[N], t_a1[N], t_lr[N];
  int gap_bad[N], a_after_r[N], l_at_r[N];
  bit l_prev[N];

  typedef struct {
    bit         rv;
    logic [1:0] d;
    int         n;
    logic [1:0] ed;
    logic [1:0] ep;
    logic [1:0] er;
  } vec_t;
  vec_t tbl[13];

  task automatic model_step(input bit rv, input logic [N-1:0] dv);
    bit tick, rise, fall, counted;
    int nd;
    tick = ((m_cyc % TICK) == TICK - 1);
    for (int i = 0; i < N; i++) begin
      if (rv) begin
        m_s1[i] = 0; m_s2[i] = 0; m_d[i] = 0; m_run[i] = 0; m_held[i] = 0;
        m_p[i] = 0; m_r[i] = 0; m_l[i] = 0; m_a[i] = 0;
      end else begin
        rise = 1'b0;
        fall = 1'b0;
        nd = m_d[i];
        if (m_s2[i] != m_d[i]) begin
          m_run[i]++;
          if (m_run[i] == CN) begin
            nd = m_s2[i];
            m_run[i] = 0;
            rise = (nd == 1);
            fall = (nd == 0);
          end
        end else begin
          m_run[i] = 0;
        end
        counted = 1'b0;
        if (m_d[i] == 0 || m_p[i] == 1) m_held[i] = 0;
        else if (tick) begin
          m_held[i]++;
          counted = 1'b1;
        end
        m_l[i] = (!fall && m_held[i] >= LONG) ? 1 : 0;
        m_a[i] = (RPT_EN[i] == 1'b1 && !fall && counted && m_held[i] >= LONG &&
                  ((m_held[i] - LONG) % RPT) == 0) ? 1 : 0;
        m_p[i] = rise;
        m_r[i] = fall;
        m_d[i] = nd;
        m_s2[i] = m_s1[i];
        m_s1[i] = (dv[i] ^ POL[i]) ? 1 : 0;
      end
    end
    m_cyc = rv ? 0 : m_cyc + 1;
  endtask

  task automatic clear_events();
    for (int i = 0; i < N; i++) begin
      n_p[i] = 0; n_r[i] = 0; n_a[i] = 0; n_l[i] = 0;
      t_p[i] = 0; t_r[i] = 0; t_a[i] = 0; t_a1[i] = 0; t_lr[i] = 0;
      gap_bad[i] = 0; a_after_r[i] = 0; l_at_r[i] = 0;
    end
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end else begin
      $display("check %s = %0d", name, act);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end else begin
      $display("check %s = %0d", name, act);
    end
  endtask

  task automatic step(input bit rv, input logic [N-1:0] dv);
    logic [N-1:0] ed, ep, er, el, ea;
    @(negedge clk);
    rst = rv;
    d_i = dv;
    @(posedge clk);
    model_step(rv, dv);
    #1;
    t++;
    for (int i = 0; i < N; i++) begin
      ed[i] = (m_d[i] != 0);
      ep[i] = (m_p[i] != 0);
      er[i] = (m_r[i] != 0);
      el[i] = (m_l[i] != 0);
      ea[i] = (m_a[i] != 0);
    end
    checks++;
    if ({d_o, p_o, r_o, l_o, a_o} !== {ed, ep, er, el, ea}) begin
      errors++;
      $display("FAIL model t=%0d actual d/p/r/l/a=%b_%b_%b_%b_%b required=%b_%b_%b_%b_%b",
               t, d_o, p_o, r_o, l_o, a_o, ed, ep, er, el, ea);
    end
    for (int i = 0; i < N; i++) begin
      if (p_o[i]) begin n_p[i]++; t_p[i] = t; end
      if (r_o[i]) begin n_r[i]++; t_r[i] = t; l_at_r[i] = l_o[i] ? 1 : 0; end
      if (a_o[i]) begin
        if (n_a[i] == 0) t_a1[i] = t;
        else if (t - t_a[i] != TICK * RPT) gap_bad[i]++;
        if (n_r[i] > 0) a_after_r[i]++;
        n_a[i]++;
        t_a[i] = t;
      end
      if (l_o[i] && !l_prev[i]) begin n_l[i]++; t_lr[i] = t; end
      l_prev[i] = (l_o[i] === 1'b1);
    end
  endtask

  task automatic steps(input bit rv, input logic [N-1:0] dv, input int n);
    for (int k = 0; k < n; k++) step(rv, dv);
  endtask

  initial begin
    int t0;
    logic [N-1:0] rd;
    int rn;

    // ch0 is active-low (idle d_i[0]=1), ch1 active-high (idle d_i[1]=0).
    tbl[0]  = '{1'b1, 2'b01,  3, 2'b00, 2'b00, 2'b00};
    tbl[1]  = '{1'b0, 2'b00,  5, 2'b00, 2'b00, 2'b00};
    tbl[2]  = '{1'b0, 2'b00,  1, 2'b01, 2'b01, 2'b00};
    tbl[3]  = '{1'b0, 2'b00,  1, 2'b01, 2'b00, 2'b00};
    tbl[4]  = '{1'b0, 2'b01,  5, 2'b01, 2'b00, 2'b00};
    tbl[5]  = '{1'b0, 2'b01,  1, 2'b00, 2'b00, 2'b01};
    tbl[6]  = '{1'b0, 2'b01,  1, 2'b00, 2'b00, 2'b00};
    tbl[7]  = '{1'b0, 2'b00,  3, 2'b00, 2'b00, 2'b00};
    tbl[8]  = '{1'b0, 2'b01, 10, 2'b00, 2'b00, 2'b00};
    tbl[9]  = '{1'b0, 2'b11,  4, 2'b00, 2'b00, 2'b00};
    tbl[10] = '{1'b0, 2'b01,  2, 2'b10, 2'b10, 2'b00};
    tbl[11] = '{1'b0, 2'b01,  4, 2'b00, 2'b00, 2'b10};
    tbl[12] = '{1'b0, 2'b01,  4, 2'b00, 2'b00, 2'b00};

    clear_events();
    for (int e = 0; e < 13; e++) begin
      steps(tbl[e].rv, tbl[e].d, tbl[e].n);
      chk($sformatf("tbl%0d_dpr", e), int'({d_o, p_o, r_o}),
          int'({tbl[e].ed, tbl[e].ep, tbl[e].er}));
    end

    // Bounce on ch1: 2-clock segments never qualify; final level presses once.
    clear_events();
    for (int k = 0; k < 5; k++) begin
      steps(1'b0, 2'b11, 2);
      steps(1'b0, 2'b01, 2);
    end
    t0 = t + 1;
    steps(1'b0, 2'b11, 12);
    chk("bounce_presses", n_p[1], 1);
    chk("bounce_latency", t_p[1] - t0 + 1, CN + 2);
    steps(1'b0, 2'b01, 12);

    // Long press with auto-repeat on ch0.
    clear_events();
    steps(1'b0, 2'b00, 40);
    steps(1'b0, 2'b01, 20);
    chk("lp_presses", n_p[0], 1);
    chk_rng("lp_l_delay", t_lr[0] - t_p[0], TICK * LONG, TICK * LONG + 1);
    chk("lp_first_a_at_l", t_a1[0], t_lr[0]);
    chk("lp_a_gaps_bad", gap_bad[0], 0);
    chk("lp_a_count", n_a[0], 5);
    chk("lp_releases", n_r[0], 1);
    chk("lp_l_in_r_cycle", l_at_r[0], 0);
    chk("lp_a_after_r", a_after_r[0], 0);

    // Long press on ch1 where repeat is disabled.
    clear_events();
    steps(1'b0, 2'b11, 40);
    chk("norpt_l_level", int'(l_o[1]), 1);
    steps(1'b0, 2'b01, 20);
    chk("norpt_l_rises", n_l[1], 1);
    chk("norpt_a_count", n_a[1], 0);

    // Reset while ch0 is repeating and still held.
    clear_events();
    steps(1'b0, 2'b00, 30);
    chk("rst_l_before", int'(l_o[0]), 1);
    step(1'b1, 2'b00);
    chk("rst_all_zero", int'({d_o, p_o, r_o, l_o, a_o}), 0);
    t0 = t + 1;
    steps(1'b0, 2'b00, 10);
    chk("rst_repress_latency", t_p[0] - t0 + 1, CN + 2);
    chk("rst_presses", n_p[0], 2);
    chk("rst_no_release", n_r[0], 0);
    steps(1'b0, 2'b01, 12);

    // Random bursts, occasionally long enough for long-press and repeat.
    for (int b = 0; b < 70; b++) begin
      rd = N'($urandom_range(0, 3));
      rn = ($urandom_range(0, 3) == 0) ? 30 : int'($urandom_range(1, 8));
      if ($urandom_range(0, 24) == 0) step(1'b1, rd);
      steps(1'b0, rd, rn);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
